pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Generic, parametrised pipeline stage register that replaces the hand-written per-stage registers (IF/ID through MEM/WB).
- Carries an opaque payload plus a "keep" field group, e.g. PC, PC+4, trap code and trap flag, that survives a flush as a bubble.
- Upgrades the fixed-width, enable-stalled register to a 2-entry skid buffer with valid/ready handshake, full throughput and a registered in_ready.

Parameters:
DATA_W, 128, width of flushable payload (rd, csr data/addr, wb data, control bits)
KEEP_W, 69, width of fields retained on clear (PC, PC+4, trap_code, is_trap)
KEEP_ON_CLEAR, 1, 1: a clear with accepted input inserts a bubble carrying in_keep; 0: clear leaves stage empty
CNT_W, 16, width of performance counters

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
clear  in  1  flush stage contents
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept; registered
in_data  in  DATA_W  upstream payload
in_keep  in  KEEP_W  upstream retained fields
out_valid  out  1  downstream entry valid
out_ready  in  1  downstream accepts (stall when low)
out_data  out  DATA_W  payload of head entry
out_keep  out  KEEP_W  retained fields of head entry
out_bubble  out  1  head entry was created by clear (payload zero)
stall_cnt  out  CNT_W  cycles with out_valid & ~out_ready
flush_cnt  out  CNT_W  clears that discarded at least one valid entry

Behaviour:
- Storage: main entry (drives outputs) and skid entry, each {data, keep, bubble}.
- Fire definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Occupancy FSM, EMPTY/ONE/TWO:
  - out_valid = (state != EMPTY).
  - in_ready = (state != TWO). It is a pure function of the state flop; there is no combinational path from in_valid, out_ready or clear.
- EMPTY: in_fire -> main<=in, ONE.
- ONE:
  - in_fire & out_fire -> main<=in, stay ONE.
  - in_fire & ~out_fire -> skid<=in, TWO.
  - ~in_fire & out_fire -> EMPTY.
  - Otherwise hold.
- TWO: out_fire -> main<=skid, ONE; otherwise hold. No input is accepted in TWO.
- Latency: 1 cycle from in_fire to out_valid when the stage is empty. Sustained throughput is 1 entry/cycle in ONE.
- Ordering: strict FIFO. Entries are never dropped or duplicated except by clear.
- clear has priority over normal transitions. All stored entries are discarded, and any out_fire in the same cycle is ignored for FSM purposes.
  - Next state with in_fire & KEEP_ON_CLEAR: main<={data=0, keep=in_keep, bubble=1}, state ONE.
  - Next state otherwise: EMPTY.
  - If clear arrives in TWO, in_ready=0, so no input is taken and the next state is EMPTY.
- Held entries are stable: data, keep and bubble are bit-stable while out_valid & ~out_ready.
- Payload of an empty stage: out_data/out_keep keep their last values, with no zeroing requirement. out_bubble=0 when EMPTY.
- Reset (async, any time, including mid-transfer):
  - state=EMPTY, out_valid=0, in_ready=1 after release.
  - main/skid data and keep=0, out_bubble=0.
  - stall_cnt=0, flush_cnt=0.
- Counters:
  - Both counters saturate at 2^CNT_W-1 and do not wrap.
  - flush_cnt increments once per clear cycle when state != EMPTY.
  - stall_cnt increments on out_valid & ~out_ready, including cycles where clear is also asserted.

Optional Feature:
- PIPE_STAGE_PERF_EN defined: stall_cnt/flush_cnt implemented as above.
- PIPE_STAGE_PERF_EN undefined: counter flops are not built and stall_cnt/flush_cnt are tied to 0. Ports stay present so that instantiations are unchanged.

Decomposition:
- Shared package pipe_pkg holds:
  - the occupancy state typedef (EMPTY/ONE/TWO, 2-bit encoding);
  - per-stage DATA_W/KEEP_W constants for IF/ID, ID/EX, EX/MEM, MEM/WB;
  - the default CNT_W.
- One natural sub-module: pipe_sat_counter (CNT_W, async reset, inc enable, saturate), instantiated twice inside the PIPE_STAGE_PERF_EN guard.

Test Plan:
- Reset mid-stream: fill to TWO, assert rst_i asynchronously between clock edges -> out_valid=0 immediately, in_ready=1 after release, counters 0.
- Streaming: in_valid=1 with data 1..20, out_ready=1 -> outputs 1..20 in order, one per cycle from cycle 1, in_ready stays 1.
- Backpressure: send A,B,C with out_ready=0 -> A held on outputs, B in skid, in_ready=0 from the cycle after B, C not accepted. Then release out_ready -> A,B,C delivered in order; stall_cnt equals the number of stalled cycles.
- Clear bubble: state ONE holding X, clear=1 with in_valid=1, in_keep=0x1234 -> next cycle out_valid=1, out_bubble=1, out_data=0, out_keep=0x1234, flush_cnt=1.
- Clear in TWO, or with KEEP_ON_CLEAR=0: -> next cycle EMPTY, in_valid input not consumed, in_ready=1.
- Counter saturation with CNT_W=4: hold a stall for 20 cycles -> stall_cnt=15. Without PIPE_STAGE_PERF_EN -> both counters read 0 throughout.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: occupancy state,
// per-stage field widths and the default performance counter width.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_t;

  localparam int PIPE_CNT_W = 16;

  // Flushable payload and retained (PC, PC+4, trap) widths per boundary
  localparam int IF_ID_DATA_W  = 64;
  localparam int IF_ID_KEEP_W  = 69;
  localparam int ID_EX_DATA_W  = 160;
  localparam int ID_EX_KEEP_W  = 69;
  localparam int EX_MEM_DATA_W = 128;
  localparam int EX_MEM_KEEP_W = 69;
  localparam int MEM_WB_DATA_W = 96;
  localparam int MEM_WB_KEEP_W = 69;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for pipeline stage performance statistics.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffer pipeline stage with valid/ready handshake and a
// registered in_ready. Counters are built only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W        = 128,
  parameter int KEEP_W        = 69,
  parameter int KEEP_ON_CLEAR = 1,
  parameter int CNT_W         = PIPE_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEEP_W-1:0] in_keep,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic              out_bubble,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  occ_state_t state, next_state;

  logic [DATA_W-1:0] main_data, skid_data;
  logic [KEEP_W-1:0] main_keep, skid_keep;
  logic              main_bubble, skid_bubble;

  logic in_fire, out_fire;
  logic load_main_in, load_main_skid, load_skid, load_bubble;

  // Handshake outputs depend only on the state flop
  assign in_ready   = (state != TWO);
  assign out_valid  = (state != EMPTY);
  assign in_fire    = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;

  assign out_data   = main_data;
  assign out_keep   = main_keep;
  assign out_bubble = main_bubble & out_valid;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  // Clear overrides every normal transition, including a same-cycle out_fire
  always_comb begin
    next_state     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    load_bubble    = 1'b0;
    if (clear) begin
      if (in_fire && (KEEP_ON_CLEAR != 0)) begin
        next_state  = ONE;
        load_bubble = 1'b1;
      end else begin
        next_state  = EMPTY;
      end
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            next_state   = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            next_state = TWO;
            load_skid  = 1'b1;
          end else if (out_fire) begin
            next_state = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            next_state     = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: begin
          next_state = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_data   <= '0;
      main_keep   <= '0;
      main_bubble <= 1'b0;
    end else if (load_bubble) begin
      main_data   <= '0;
      main_keep   <= in_keep;
      main_bubble <= 1'b1;
    end else if (load_main_in) begin
      main_data   <= in_data;
      main_keep   <= in_keep;
      main_bubble <= 1'b0;
    end else if (load_main_skid) begin
      main_data   <= skid_data;
      main_keep   <= skid_keep;
      main_bubble <= skid_bubble;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      skid_data   <= '0;
      skid_keep   <= '0;
      skid_bubble <= 1'b0;
    end else if (load_skid) begin
      skid_data   <= in_data;
      skid_keep   <= in_keep;
      skid_bubble <= 1'b0;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic stall_inc, flush_inc;

  assign stall_inc = out_valid & ~out_ready;
  assign flush_inc = clear & out_valid;

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (flush_inc),
    .count (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_pipe_stage_skid;

  localparam int DW    = 16;
  localparam int KW    = 16;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;
`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [KW-1:0] in_keep = '0;

  logic          in_ready, out_valid, out_bubble;
  logic [DW-1:0] out_data;
  logic [KW-1:0] out_keep;
  logic [CW-1:0] stall_cnt, flush_cnt;

  logic          in_ready2, out_valid2, out_bubble2;
  logic [DW-1:0] out_data2;
  logic [KW-1:0] out_keep2;
  logic [CW-1:0] stall_cnt2, flush_cnt2;

  int assertions = 0;
  int failures   = 0;

  always #5 clk_i = ~clk_i;

  pipe_stage_skid #(.DATA_W(DW), .KEEP_W(KW), .KEEP_ON_CLEAR(1), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_keep(in_keep),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_keep(out_keep), .out_bubble(out_bubble),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_stage_skid #(.DATA_W(DW), .KEEP_W(KW), .KEEP_ON_CLEAR(0), .CNT_W(CW)) dut_nokeep (
    .clk_i(clk_i), .rst_i(rst_i), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_keep(in_keep),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_keep(out_keep2), .out_bubble(out_bubble2),
    .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  typedef struct {
    logic          iv, ordy, clr;
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          e_ov, e_ir, chk_d;
    logic [DW-1:0] e_d;
    logic [KW-1:0] e_k;
    logic          e_bub;
    int            e_stall, e_flush;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          bubble;
  } ent_t;

  vec_t vecs[9];
  ent_t model_q[$];
  int   model_stall, model_flush;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic ordy, input logic clr,
                               input logic [DW-1:0] d, input logic [KW-1:0] k);
    in_valid  = iv;
    out_ready = ordy;
    clear     = clr;
    in_data   = d;
    in_keep   = k;
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic doReset();
    @(negedge clk_i);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  function automatic vec_t mkVec(logic iv, logic ordy, logic clr, logic [DW-1:0] d,
                                 logic [KW-1:0] k, logic e_ov, logic e_ir, logic chk_d,
                                 logic [DW-1:0] e_d, logic [KW-1:0] e_k, logic e_bub,
                                 int e_stall, int e_flush);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.clr = clr; v.d = d; v.k = k;
    v.e_ov = e_ov; v.e_ir = e_ir; v.chk_d = chk_d; v.e_d = e_d; v.e_k = e_k;
    v.e_bub = e_bub; v.e_stall = e_stall; v.e_flush = e_flush;
    return v;
  endfunction

  function automatic int satInc(int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  initial begin
    // Backpressure A,B,C then drain, then a clear that leaves a bubble
    vecs[0] = mkVec(1, 0, 0, 16'h00A1, 16'h0A01, 1, 1, 1, 16'h00A1, 16'h0A01, 0, 0, 0);
    vecs[1] = mkVec(1, 0, 0, 16'h00B1, 16'h0B01, 1, 0, 1, 16'h00A1, 16'h0A01, 0, 1, 0);
    vecs[2] = mkVec(1, 0, 0, 16'h00C1, 16'h0C01, 1, 0, 1, 16'h00A1, 16'h0A01, 0, 2, 0);
    vecs[3] = mkVec(1, 1, 0, 16'h00C1, 16'h0C01, 1, 1, 1, 16'h00B1, 16'h0B01, 0, 2, 0);
    vecs[4] = mkVec(1, 1, 0, 16'h00C1, 16'h0C01, 1, 1, 1, 16'h00C1, 16'h0C01, 0, 2, 0);
    vecs[5] = mkVec(0, 1, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h0000, 16'h0000, 0, 2, 0);
    vecs[6] = mkVec(1, 0, 0, 16'h00D1, 16'h0D01, 1, 1, 1, 16'h00D1, 16'h0D01, 0, 2, 0);
    vecs[7] = mkVec(1, 0, 1, 16'h00E1, 16'h1234, 1, 1, 1, 16'h0000, 16'h1234, 1, 3, 1);
    vecs[8] = mkVec(0, 1, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h0000, 16'h0000, 0, 3, 1);

    rst_i = 1'b1;
    #12;
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset_out_bubble", {31'd0, out_bubble}, 32'd0);
    checkOutput("reset_out_data", {16'd0, out_data}, 32'd0);
    checkOutput("reset_stall_cnt", {28'd0, stall_cnt}, 32'd0);
    checkOutput("reset_flush_cnt", {28'd0, flush_cnt}, 32'd0);

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].iv, vecs[i].ordy, vecs[i].clr, vecs[i].d, vecs[i].k);
      step();
      checkOutput($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
      checkOutput($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_ir});
      checkOutput($sformatf("vec%0d_out_bubble", i), {31'd0, out_bubble}, {31'd0, vecs[i].e_bub});
      if (vecs[i].chk_d) begin
        checkOutput($sformatf("vec%0d_out_data", i), {16'd0, out_data}, {16'd0, vecs[i].e_d});
        checkOutput($sformatf("vec%0d_out_keep", i), {16'd0, out_keep}, {16'd0, vecs[i].e_k});
      end
      checkOutput($sformatf("vec%0d_stall_cnt", i), {28'd0, stall_cnt},
                  PERF ? vecs[i].e_stall : 0);
      checkOutput($sformatf("vec%0d_flush_cnt", i), {28'd0, flush_cnt},
                  PERF ? vecs[i].e_flush : 0);
    end

    // Streaming 1..20 at full rate
    doReset();
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, DW'(i), KW'(i + 100));
      step();
      checkOutput($sformatf("stream%0d_data", i), {16'd0, out_data}, i);
      checkOutput($sformatf("stream%0d_valid", i), {31'd0, out_valid}, 32'd1);
      checkOutput($sformatf("stream%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
    step();
    checkOutput("stream_drain_valid", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset while full
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0011, 16'h0022);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0033, 16'h0044);
    step();
    checkOutput("midrst_full_in_ready", {31'd0, in_ready}, 32'd0);
    #2 rst_i = 1'b1;
    #1;
    checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_stall_cnt", {28'd0, stall_cnt}, 32'd0);
    checkOutput("midrst_flush_cnt", {28'd0, flush_cnt}, 32'd0);
    checkOutput("midrst_out_bubble", {31'd0, out_bubble}, 32'd0);
    @(negedge clk_i);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    rst_i = 1'b0;
    step();
    checkOutput("midrst_release_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("midrst_release_valid", {31'd0, out_valid}, 32'd0);

    // Clear while TWO: nothing taken, stage empties
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0101, 16'h0202);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0303, 16'h0404);
    step();
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0505, 16'h0606);
    step();
    checkOutput("clr_two_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("clr_two_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("clr_two_flush_cnt", {28'd0, flush_cnt}, PERF ? 1 : 0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
    step();
    checkOutput("clr_two_stays_empty", {31'd0, out_valid}, 32'd0);

    // KEEP_ON_CLEAR=0 instance: clear with accepted input leaves it empty
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0707, 16'h0808);
    step();
    checkOutput("nokeep_one_valid", {31'd0, out_valid2}, 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0909, 16'h1234);
    step();
    checkOutput("nokeep_clr_valid", {31'd0, out_valid2}, 32'd0);
    checkOutput("nokeep_clr_in_ready", {31'd0, in_ready2}, 32'd1);
    checkOutput("nokeep_clr_bubble", {31'd0, out_bubble2}, 32'd0);
    checkOutput("nokeep_flush_cnt", {28'd0, flush_cnt2}, PERF ? 1 : 0);
    checkOutput("keep_clr_bubble", {31'd0, out_bubble}, 32'd1);
    checkOutput("keep_clr_keep", {16'd0, out_keep}, 32'h1234);

    // Stall counter saturation
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0AAA, 16'h0BBB);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 20; i++) begin
      step();
      checkOutput($sformatf("sat_hold_data%0d", i), {16'd0, out_data}, 32'h0AAA);
    end
    checkOutput("sat_stall_cnt", {28'd0, stall_cnt}, PERF ? CMAX : 0);
    checkOutput("sat_flush_cnt", {28'd0, flush_cnt}, 32'd0);

    // Randomized run against the queue model
    doReset();
    model_q.delete();
    model_stall = 0;
    model_flush = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic iv, ordy, clr, acc, pop;
      ent_t e;
      checkOutput($sformatf("rnd%0d_out_valid", cyc), {31'd0, out_valid},
                  (model_q.size() > 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("rnd%0d_in_ready", cyc), {31'd0, in_ready},
                  (model_q.size() < 2) ? 32'd1 : 32'd0);
      if (model_q.size() > 0) begin
        checkOutput($sformatf("rnd%0d_data", cyc), {16'd0, out_data}, {16'd0, model_q[0].data});
        checkOutput($sformatf("rnd%0d_keep", cyc), {16'd0, out_keep}, {16'd0, model_q[0].keep});
        checkOutput($sformatf("rnd%0d_bubble", cyc), {31'd0, out_bubble}, {31'd0, model_q[0].bubble});
      end else begin
        checkOutput($sformatf("rnd%0d_bubble_empty", cyc), {31'd0, out_bubble}, 32'd0);
      end
      checkOutput($sformatf("rnd%0d_stall_cnt", cyc), {28'd0, stall_cnt}, PERF ? model_stall : 0);
      checkOutput($sformatf("rnd%0d_flush_cnt", cyc), {28'd0, flush_cnt}, PERF ? model_flush : 0);

      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      clr  = ($urandom_range(0, 19) == 0);
      applyStimulus(iv, ordy, clr, DW'($urandom), KW'($urandom));
      @(posedge clk_i);
      acc = iv && (model_q.size() < 2);
      pop = ordy && (model_q.size() > 0);
      if ((model_q.size() > 0) && !ordy) model_stall = satInc(model_stall);
      e.data = in_data;
      e.keep = in_keep;
      e.bubble = 1'b0;
      if (clr) begin
        if (model_q.size() > 0) model_flush = satInc(model_flush);
        model_q.delete();
        if (acc) begin
          e.data = '0;
          e.bubble = 1'b1;
          model_q.push_back(e);
        end
      end else begin
        if (pop) void'(model_q.pop_front());
        if (acc) model_q.push_back(e);
      end
      @(negedge clk_i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
